// File: rtl/eth_frame_stream_gen.sv
// AXI-Stream Ethernet frame source: DA/SA/EtherType header, counting payload, zero padding to 60 bytes.
// Define ETH_GEN_IFG_EN to insert IFG_CYCLES idle cycles between frames of a burst.
module eth_frame_stream_gen #(
  parameter int DATA_W      = 32,
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46,
  parameter int IFG_CYCLES  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [47:0]         i_dest_mac,
  input  logic [47:0]         i_src_mac,
  input  logic [15:0]         i_ether_type,
  input  logic [10:0]         i_payload_len,
  input  logic [15:0]         i_frame_count,
  input  logic                i_tx_tready,
  output logic [DATA_W-1:0]   o_tx_data,
  output logic [DATA_W/8-1:0] o_tx_tkeep,
  output logic                o_tx_tvalid,
  output logic                o_tx_tlast,
  output logic                o_busy,
  output logic                o_done,
  output logic [15:0]         o_frames_sent
);
  // state | meaning
  // IDLE  | waiting for i_start, config may change freely
  // SEND  | presenting frame beats, advancing on tvalid & tready
  // GAP   | inter-frame idle (ETH_GEN_IFG_EN builds only)
  // DONE  | one-cycle o_done pulse, then back to IDLE
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(14 + MAX_PAYLOAD + BYTES + 1);
  localparam int K_W   = CNT_W + 1;
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [K_W-1:0] HDR_LEN = K_W'(14);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
  state_t state, state_nxt;

  logic [47:0]      da_q, sa_q;
  logic [15:0]      type_q;
  logic [CNT_W-1:0] pay_len_q, frame_len_q, ptr_q;
  logic [CNT_W-1:0] pay_len_c, frame_len_c;
  logic [15:0]      frames_left_q, frames_sent_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [111:0]     hdr, hdr_sh;
  logic [K_W-1:0]   k;
  logic             start_ok, beat_xfer, last_beat, frame_end, burst_end;

  assign hdr       = {da_q, sa_q, type_q};
  assign start_ok  = (state == S_IDLE) && i_start;
  assign beat_xfer = (state == S_SEND) && i_tx_tready;
  assign last_beat = ({1'b0, ptr_q} + K_W'(BYTES)) >= {1'b0, frame_len_q};
  assign frame_end = beat_xfer && last_beat;
  assign burst_end = frame_end && (frames_left_q == 16'd1);

  // Payload clamp, then frame length with minimum-size padding
  always_comb begin
    pay_len_c   = CNT_W'(i_payload_len);
    frame_len_c = '0;
    if (int'(i_payload_len) > MAX_PAYLOAD) pay_len_c = CNT_W'(MAX_PAYLOAD);
    if (int'(pay_len_c) < MIN_PAYLOAD) frame_len_c = CNT_W'(14 + MIN_PAYLOAD);
    else                               frame_len_c = pay_len_c + CNT_W'(14);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_tx_tvalid = 1'b0;
    o_tx_tlast  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_SEND;
      S_SEND: begin
        o_tx_tvalid = 1'b1;
        o_tx_tlast  = last_beat;
        o_busy      = 1'b1;
        if (frame_end) begin
          if (burst_end) state_nxt = S_DONE;
`ifdef ETH_GEN_IFG_EN
          else if (IFG_CYCLES > 0) state_nxt = S_GAP;
`endif
        end
      end
      S_GAP: begin
        o_busy = 1'b1;
        if (gap_cnt_q == '0) state_nxt = S_SEND;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_q          <= '0;
      sa_q          <= '0;
      type_q        <= '0;
      pay_len_q     <= '0;
      frame_len_q   <= '0;
      ptr_q         <= '0;
      frames_left_q <= '0;
      frames_sent_q <= '0;
      gap_cnt_q     <= '0;
    end else begin
      if (start_ok) begin
        da_q          <= i_dest_mac;
        sa_q          <= i_src_mac;
        type_q        <= i_ether_type;
        pay_len_q     <= pay_len_c;
        frame_len_q   <= frame_len_c;
        ptr_q         <= '0;
        frames_sent_q <= '0;
        frames_left_q <= (i_frame_count == 16'd0) ? 16'd1 : i_frame_count;
      end else if (beat_xfer) begin
        if (last_beat) begin
          ptr_q         <= '0;
          frames_sent_q <= frames_sent_q + 16'd1;
          frames_left_q <= frames_left_q - 16'd1;
        end else begin
          ptr_q <= ptr_q + CNT_W'(BYTES);
        end
      end
      // Reloaded outside GAP so the gap always lasts exactly IFG_CYCLES
      if (state == S_GAP) gap_cnt_q <= gap_cnt_q - 1'b1;
      else                gap_cnt_q <= GAP_W'(IFG_CYCLES - 1);
    end
  end

  always_comb begin
    o_tx_data  = '0;
    o_tx_tkeep = '0;
    k          = '0;
    hdr_sh     = '0;
    if (state == S_SEND) begin
      for (int i = 0; i < BYTES; i++) begin
        k      = {1'b0, ptr_q} + K_W'(i);
        hdr_sh = hdr << {k[3:0], 3'b000};
        if (k < {1'b0, frame_len_q}) begin
          o_tx_tkeep[BYTES-1-i] = 1'b1;
          if (k < HDR_LEN)
            o_tx_data[DATA_W-1-8*i -: 8] = hdr_sh[111:104];
          else if (k < HDR_LEN + {1'b0, pay_len_q})
            o_tx_data[DATA_W-1-8*i -: 8] = 8'(k - HDR_LEN);
        end
      end
    end
  end

  assign o_frames_sent = frames_sent_q;

endmodule
